// File: rtl/ps2_host_rx.sv
// Host-side PS/2 device-to-host receiver: synchronise, edge-detect, deserialise 11-bit frames.
// Optional clock glitch filter enabled by defining PS2_RX_GLITCH_FILTER_EN.
module ps2_host_rx #(
    parameter int unsigned FILTER_LEN   = 8,
    parameter int unsigned TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout_err,
    output logic       rx_busy
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_filter_len_chk
        $error("ps2_host_rx: FILTER_LEN must be in 2..255");
    end

    // Two-stage synchronisers, reset to the bus idle level
    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_s;
    logic       dat_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    logic kclk;

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int unsigned FLT_W = 8;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             kclk_q;

    // kclk follows clk_s only after FILTER_LEN consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt_q <= '0;
            kclk_q    <= 1'b1;
        end else if (clk_s == kclk_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            flt_cnt_q <= '0;
            kclk_q    <= clk_s;
        end else begin
            flt_cnt_q <= flt_cnt_q + FLT_W'(1);
        end
    end

    assign kclk = kclk_q;
`else
    assign kclk = clk_s;
`endif

    logic kclk_d_q;
    logic fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) kclk_d_q <= 1'b1;
        else        kclk_d_q <= kclk;
    end

    assign fall = ~kclk & kclk_d_q;

    logic [1:0]              state_q, state_d;
    logic [DATA_W-1:0]       sr_q, sr_d;
    logic                    par_q, par_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
    logic [DATA_W-1:0]       rx_data_q, rx_data_d;
    logic                    valid_q, valid_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic                    terr_q, terr_d;
    logic                    busy_q;
    logic                    wdog_exp;

    assign wdog_exp = (state_q != S_IDLE) && (&wdog_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            wdog_q    <= '0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            terr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            wdog_q    <= wdog_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            terr_q    <= terr_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    // Next state: rx_en low beats watchdog expiry, which beats a clock fall
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;
        wdog_d    = (state_q == S_IDLE || fall) ? '0 : wdog_q + TIMEOUT_BITS'(1);

        if (!rx_en) begin
            state_d = S_IDLE;
        end else if (wdog_exp) begin
            state_d = S_IDLE;
            terr_d  = 1'b1;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    sr_d      = {dat_s, sr_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                default: begin
                    rx_data_d = sr_q;
                    state_d   = S_IDLE;
                    if (!dat_s)               ferr_d  = 1'b1;
                    else if (^{sr_q, par_q})  valid_d = 1'b1;
                    else                      perr_d  = 1'b1;
                end
            endcase
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_valid       = valid_q;
    assign rx_parity_err  = perr_q;
    assign rx_frame_err   = ferr_q;
    assign rx_timeout_err = terr_q;
    assign rx_busy        = busy_q;

endmodule

// File: doc/ps2_host_rx.md
# ps2_host_rx

Host-side PS/2 receiver for device-to-host frames, such as keyboard scan codes. It sits beside the host transmitter on the same open-collector `ps2_clk`/`ps2_data` pair and only observes the bus; it never drives it. It deserialises 11-bit frames (start, 8 data bits LSB-first, odd parity, stop) into bytes for the keyboard decoder. It flags parity, framing and timeout errors.

## Interface
Parameters:
- `FILTER_LEN`, default 8: number of consecutive stable `clk` cycles required before the filtered PS/2 clock changes. Legal range 2..255.
- `TIMEOUT_BITS`, default 16: width of the inter-edge watchdog counter. The timeout is 2^TIMEOUT_BITS−1 cycles, about 1.31 ms at 50 MHz.

Ports:
- `clk` input 1: system clock. All logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `ps2_clk_in` input 1: raw PS/2 clock from the pad. Asynchronous.
- `ps2_data_in` input 1: raw PS/2 data from the pad. Asynchronous.
- `rx_en` input 1: receive enable. Held low by the system while the host transmitter owns the bus.
- `rx_data` output 8: last completed frame's data byte.
- `rx_valid` output 1: one-cycle pulse for a good frame.
- `rx_parity_err` output 1: one-cycle pulse for a frame with bad parity.
- `rx_frame_err` output 1: one-cycle pulse for a frame whose stop bit is 0.
- `rx_timeout_err` output 1: one-cycle pulse when a frame is abandoned by the watchdog.
- `rx_busy` output 1: high while a frame is in progress, i.e. in any state other than IDLE.

## Operation
- **Input synchronisation:**
  - Each of `ps2_clk_in` and `ps2_data_in` passes through a 2-FF synchroniser.
  - The synchronised clock then passes through the optional glitch filter (see Configuration) to produce `kclk`.
- **Edge detection:** a register `kclk_d` holds the previous `kclk`. `fall = ~kclk & kclk_d`. All data is sampled from the synchronised data bit on the cycle `fall` is high.
- **State machine:** states are IDLE, DATA, PARITY, STOP. Behaviour on `fall`:
  - IDLE: if data = 0 (start bit) and `rx_en`=1, go to DATA and clear `bit_cnt` to 0. If data = 1, stay in IDLE with no pulse.
  - DATA: shift right, `sr <= {data, sr[7:1]}`, and increment `bit_cnt`. After the 8th bit (`bit_cnt` = 7 on that edge), go to PARITY.
  - PARITY: capture the parity bit into `par`, then go to STOP.
  - STOP: load `rx_data <= sr` and return to IDLE.
    - If stop = 0: pulse `rx_frame_err` only.
    - Otherwise, if `^{sr,par}` = 1: pulse `rx_valid`.
    - Otherwise: pulse `rx_parity_err`.
  - Exactly one of the three pulses fires per completed frame.
- **Watchdog:**
  - The counter clears in IDLE and on every `fall`, and increments otherwise.
  - If it reaches all-ones in a non-IDLE state: go to IDLE, pulse `rx_timeout_err`, and leave `rx_data` unchanged.
- **Receive disable:** `rx_en`=0 in any state forces IDLE on the next cycle with no pulse. `rx_data` is unchanged.
- **Priority on a single cycle:** `rx_en`=0 overrides watchdog expiry, which overrides `fall`.
- **Reset:**
  - All outputs are 0: `rx_data`=0x00, `rx_valid`, all error pulses, and `rx_busy`.
  - The state is IDLE; `sr`, `par`, `bit_cnt` and the watchdog are 0.
  - Synchroniser and filter registers reset to 1, the bus idle level, so the release of reset never produces a false `fall`.
  - Reset asserted mid-frame discards the frame immediately.

## Timing
- Synchroniser latency is 2 cycles. The filter adds `FILTER_LEN` cycles when compiled in.
- The state update happens on the cycle `fall` is high.
- `rx_valid` or an error pulse is registered: it is high on the cycle after the stop-bit `fall`, for exactly 1 cycle.
- `rx_data` is valid from the same cycle as the pulse and holds until the next completed frame.
- `rx_busy` rises the cycle after the start-bit `fall` and falls together with the completion pulse.
- There is no back-pressure. The consumer must accept `rx_valid` on the cycle it is high.
- Back-to-back frames are supported. IDLE accepts a start bit on the first `fall` after a STOP.

## Configuration
- Macro: `PS2_RX_GLITCH_FILTER_EN`.
- **Defined:** `kclk` changes only after the synchronised clock has differed from `kclk` for `FILTER_LEN` consecutive cycles. The counter resets on any agreement. Low or high pulses shorter than `FILTER_LEN` cycles are ignored.
- **Undefined:** `kclk` equals the synchronised clock, and `FILTER_LEN` is unused.

## Test plan
- **Good frame:** bit sequence 0, 0,0,1,1,1,0,0,0, parity 0, stop 1, at a 12.5 kHz PS/2 clock. Expect `rx_data`=0x1C, one `rx_valid` pulse, all error pulses 0, and `rx_busy` high for the frame.
- **Parity error:** the same frame with parity = 1. Expect `rx_parity_err` pulse, `rx_valid`=0, `rx_data`=0x1C.
- **Framing error:** frame 0xF0 with correct parity 1 and stop = 0. Expect `rx_frame_err` pulse only, `rx_data`=0xF0.
- **Timeout:** with `TIMEOUT_BITS`=8, stop the clock after 4 data bits. Expect `rx_timeout_err` 255 cycles after the last `fall`, then IDLE. A following good 0x1C frame must be received correctly.
- **rx_en abort and glitch:** drop `rx_en` after bit 3, which must give no pulse and `rx_busy` 0 the next cycle. Then, with the macro defined and `FILTER_LEN`=8, inject a 3-cycle low glitch on `ps2_clk_in` in IDLE while data = 0: expect no state change.
- **Reset mid-frame:** assert `rst_n`=0 at bit 5. Expect all outputs 0 asynchronously and no spurious pulse after release.
